// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : regfile_wb_arbiter_pkg                                 |
// | Description : Shared widths, register-zero constant and the write    |
// |               entry layout used by the register-file write front end.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package regfile_wb_arbiter_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    // One buffered register-file write: destination above data.
    typedef struct packed {
        logic [REG_AW-1:0] wa;
        logic [REG_DW-1:0] wd;
    } wb_entry_t;

    localparam int WB_EW = REG_AW + REG_DW;

    // $0 is hardwired; writes to it are swallowed.
    function automatic logic is_zero_reg(input logic [REG_AW-1:0] addr);
        return addr == REG_ZERO;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wb_fifo                                                |
// | Description : Generic DEPTH-entry synchronous FIFO with extra-bit    |
// |               wrap pointers and a registered-array head view.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] PTR_ONE = 1;

    logic [IW:0]      wr_ptr;
    logic [IW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Full when the index bits match but the wrap bits differ.
    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
        do_push   = push && !full;
        do_pop    = pop && !empty;
        head_data = mem[rd_ptr[IW-1:0]];
    end

    // Pointer advance; reset discards all contents at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[IW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : regfile_wb_arbiter                                     |
// | Description : Register-file write port owner. Merges the in-order    |
// |               pipeline writeback (priority) with buffered slow-unit  |
// |               results, bounds slow-path starvation and tracks        |
// |               registers awaiting a long-latency result.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p_we,
    input  logic [4:0]  p_wa,
    input  logic [31:0] p_wd,
    output logic        p_stall,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [4:0]  s_wa,
    input  logic [31:0] s_wd,
    input  logic        iss_valid,
    input  logic [4:0]  iss_wa,
    output logic [31:0] busy,
    output logic        we,
    output logic [4:0]  wa,
    output logic [31:0] wd,
    output logic        waw_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_ONE = 1;

    wb_entry_t          s_entry;
    wb_entry_t          head;
    logic [WB_EW-1:0]   head_bits;
    logic               fifo_full;
    logic               fifo_empty;
    logic               force_fifo;
    logic               pipe_win;
    logic               fifo_win;
    logic [SW-1:0]      starve_cnt;
    logic [SW-1:0]      starve_nxt;
    logic               we_nxt;
    logic [REG_AW-1:0]  wa_nxt;
    logic [REG_DW-1:0]  wd_nxt;
    logic [31:0]        busy_nxt;
    logic               waw_hit;

    assign s_entry = '{wa: s_wa, wd: s_wd};
    assign head    = head_bits;
    assign s_ready = !fifo_full;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WB_EW)
    ) u_wb_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s_valid),
        .push_data (s_entry),
        .pop       (fifo_win),
        .head_data (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Arbitration: pipeline first unless the slow path has waited too long.
    always_comb begin
        force_fifo = !fifo_empty && (starve_cnt == STARVE_LIM);
        p_stall    = force_fifo && p_we;
        pipe_win   = p_we && !force_fifo;
        fifo_win   = !pipe_win && !fifo_empty;
    end

    // Next write-port, scoreboard and starvation state.
    always_comb begin
        we_nxt     = 1'b0;
        wa_nxt     = wa;
        wd_nxt     = wd;
        busy_nxt   = busy;
        starve_nxt = '0;
        waw_hit    = p_we && !is_zero_reg(p_wa) && busy[p_wa];

        // A $0 winner still takes its slot but never raises the enable.
        if (pipe_win) begin
            we_nxt = !is_zero_reg(p_wa);
            wa_nxt = p_wa;
            wd_nxt = p_wd;
        end else if (fifo_win) begin
            we_nxt = !is_zero_reg(head.wa);
            wa_nxt = head.wa;
            wd_nxt = head.wd;
        end

        // Clear before set so a same-cycle issue to the same register wins.
        if (fifo_win)
            busy_nxt[head.wa] = 1'b0;
        if (iss_valid && !is_zero_reg(iss_wa))
            busy_nxt[iss_wa] = 1'b1;
        busy_nxt[0] = 1'b0;

        // Count pipeline wins only while something is waiting in the FIFO.
        if (pipe_win && !fifo_empty)
            starve_nxt = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + STARVE_ONE;
    end

    // State registers; asynchronous reset drops the write enable at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we         <= 1'b0;
            wa         <= '0;
            wd         <= '0;
            busy       <= '0;
            waw_err    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            we         <= we_nxt;
            wa         <= wa_nxt;
            wd         <= wd_nxt;
            busy       <= busy_nxt;
            starve_cnt <= starve_nxt;
            if (waw_hit) waw_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_regfile_wb_arbiter                                  |
// | Description : Scoreboard bench for regfile_wb_arbiter. Expected      |
// |               register-file writes are queued in the order the       |
// |               arbitration rules dictate and matched as they appear.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p_we;
    logic [4:0]  p_wa;
    logic [31:0] p_wd;
    logic        p_stall;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_wa;
    logic [31:0] s_wd;
    logic        iss_valid;
    logic [4:0]  iss_wa;
    logic [31:0] busy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        waw_err;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [36:0] exp_q [$];
    logic [36:0] mon_e;
    logic [31:0] sd [4];

    regfile_wb_arbiter #(
        .DEPTH      (4),
        .STARVE_MAX (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p_we      (p_we),
        .p_wa      (p_wa),
        .p_wd      (p_wd),
        .p_stall   (p_stall),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_wa      (s_wa),
        .s_wd      (s_wd),
        .iss_valid (iss_valid),
        .iss_wa    (iss_wa),
        .busy      (busy),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .waw_err   (waw_err)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic exp_push(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p_we      = 1'b0;
        p_wa      = '0;
        p_wd      = '0;
        s_valid   = 1'b0;
        s_wa      = '0;
        s_wd      = '0;
        iss_valid = 1'b0;
        iss_wa    = '0;
    endtask

    // Every visible write must be the next one the bench expects.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_value("spurious_we", 64'(we), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_value("wr_addr", 64'(wa), 64'(mon_e[36:32]));
                check_value("wr_data", 64'(wd), 64'(mon_e[31:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) step();
        check_value("rst_we",      64'(we),      64'd0);
        check_value("rst_wa",      64'(wa),      64'd0);
        check_value("rst_wd",      64'(wd),      64'd0);
        check_value("rst_busy",    64'(busy),    64'd0);
        check_value("rst_waw",     64'(waw_err), 64'd0);
        check_value("rst_s_ready", 64'(s_ready), 64'd1);
        check_value("rst_p_stall", 64'(p_stall), 64'd0);
        rst_n = 1'b1;
        step();

        // Single pipeline write, one-cycle latency.
        p_we = 1'b1; p_wa = 5'd3; p_wd = 32'h11;
        exp_push(5'd3, 32'h11);
        step();
        p_we = 1'b0;
        check_value("pipe_we_high", 64'(we), 64'd1);
        step();
        check_value("pipe_we_low", 64'(we), 64'd0);

        // Back-to-back random pipeline writes.
        for (int i = 0; i < 4; i++) begin
            p_we = 1'b1;
            p_wa = 5'($urandom_range(1, 31));
            p_wd = $urandom;
            exp_push(p_wa, p_wd);
            step();
        end
        p_we = 1'b0;
        repeat (2) step();

        // Slow path with scoreboard set/clear.
        iss_valid = 1'b1; iss_wa = 5'd7;
        step();
        iss_valid = 1'b0;
        check_value("busy_after_issue", 64'(busy), 64'h80);
        step();
        s_valid = 1'b1; s_wa = 5'd7; s_wd = 32'hDEAD;
        check_value("slow_s_ready", 64'(s_ready), 64'd1);
        exp_push(5'd7, 32'hDEAD);
        step();
        s_valid = 1'b0;
        check_value("busy7_queued", 64'(busy[7]), 64'd1);
        check_value("slow_not_yet", 64'(we), 64'd0);
        step();
        check_value("slow_we", 64'(we), 64'd1);
        check_value("busy_cleared", 64'(busy), 64'd0);
        step();

        // Starvation: 8 pipeline wins with a waiting entry, then a forced pop.
        for (int k = 0; k <= 8; k++) exp_push(5'(10 + k), 32'hA000_0000 + k);
        exp_push(5'd9, 32'hBEEF);
        exp_push(5'd19, 32'hA000_0009);
        exp_push(5'd20, 32'hA000_000A);
        for (int i = 0; i < 12; i++) begin
            int k;
            k = (i <= 9) ? i : i - 1;
            s_valid = (i == 0);
            s_wa    = 5'd9;
            s_wd    = 32'hBEEF;
            p_we    = 1'b1;
            p_wa    = 5'(10 + k);
            p_wd    = 32'hA000_0000 + k;
            #1;
            check_value($sformatf("p_stall_c%0d", i), 64'(p_stall), 64'(i == 9));
            step();
        end
        idle_inputs();
        repeat (2) step();

        // Fill the FIFO behind a busy pipeline; a 5th offer must be refused.
        for (int i = 0; i < 4; i++) sd[i] = $urandom;
        for (int i = 0; i < 5; i++) exp_push(5'(24 + i), 32'hB000_0000 + i);
        for (int i = 0; i < 4; i++) exp_push(5'(16 + i), sd[i]);
        for (int i = 0; i < 6; i++) begin
            p_we    = (i < 5);
            p_wa    = 5'(24 + i);
            p_wd    = 32'hB000_0000 + i;
            s_valid = 1'b1;
            s_wa    = (i < 4) ? 5'(16 + i) : 5'd30;
            s_wd    = (i < 4) ? sd[i] : 32'hBAD0_0000;
            #1;
            check_value($sformatf("s_ready_c%0d", i), 64'(s_ready), 64'(i < 4));
            step();
        end
        idle_inputs();
        #1;
        check_value("ready_after_pop", 64'(s_ready), 64'd1);
        repeat (5) step();

        // $0 writes from both sources consume their slot without a write.
        s_valid = 1'b1; s_wa = 5'd0; s_wd = 32'h1234;
        step();
        s_valid = 1'b0;
        p_we = 1'b1; p_wa = 5'd0; p_wd = 32'h99;
        step();
        p_we = 1'b0;
        repeat (2) step();
        check_value("zero_no_busy", 64'(busy), 64'd0);

        // Pipeline write to a busy register: sticky error, write proceeds.
        iss_valid = 1'b1; iss_wa = 5'd5;
        step();
        iss_valid = 1'b0;
        check_value("busy5", 64'(busy), 64'h20);
        check_value("waw_pre", 64'(waw_err), 64'd0);
        p_we = 1'b1; p_wa = 5'd5; p_wd = 32'h55;
        exp_push(5'd5, 32'h55);
        step();
        p_we = 1'b0;
        check_value("waw_set", 64'(waw_err), 64'd1);
        repeat (3) step();
        check_value("waw_sticky", 64'(waw_err), 64'd1);

        // Same-cycle issue and FIFO clear of one register: set wins.
        iss_valid = 1'b1; iss_wa = 5'd6;
        step();
        iss_valid = 1'b0;
        s_valid = 1'b1; s_wa = 5'd6; s_wd = 32'h66;
        exp_push(5'd6, 32'h66);
        step();
        s_valid = 1'b0;
        iss_valid = 1'b1; iss_wa = 5'd6;
        step();
        iss_valid = 1'b0;
        check_value("busy_set_wins", 64'(busy), 64'h60);
        step();

        // Reset while three slow entries are queued.
        for (int i = 0; i < 3; i++) begin
            iss_valid = (i == 0); iss_wa = 5'd7;
            p_we = 1'b1; p_wa = 5'(12 + i); p_wd = 32'hC0 + i;
            exp_push(p_wa, p_wd);
            s_valid = 1'b1; s_wa = 5'(7 - i); s_wd = 32'hD0 + i;
            step();
        end
        idle_inputs();
        check_value("busy_pre_reset", 64'(busy), 64'hE0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_value("async_we",      64'(we),      64'd0);
        check_value("async_busy",    64'(busy),    64'd0);
        check_value("async_s_ready", 64'(s_ready), 64'd1);
        check_value("async_waw",     64'(waw_err), 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (6) step();
        check_value("post_rst_busy",  64'(busy),    64'd0);
        check_value("post_rst_ready", 64'(s_ready), 64'd1);

        check_value("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
